// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq
// -----------------------------------------------------------------------------
// Registered scan sequencer for a 3-to-8 enabled decoder. When a start request
// is accepted, it drives the decoder select (addr) through codes 0..2^ADDR_W-1
// with the enable (en) high. Each code is held for dwell+1 cycles, so exactly
// one decoder output is active at any time. The controller sees busy while a
// scan runs and a one-cycle done pulse when a pass completes normally. An abort
// (stop) discards any partial pass.
//
// Optional build macro:
//   SCAN_CONT_EN - continuous mode. The scan wraps from the last code back to
//                  0 with no gap. done pulses on the first cycle of code 0
//                  after each wrap. Only stop or rst ends the scan.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active high
//   start  in   begin a scan (sampled only in IDLE)
//   stop   in   abort the scan (sampled in every state, wins over start)
//   dwell  in   hold count per code, captured when start is accepted
//   en     out  decoder enable
//   addr   out  decoder select
//   busy   out  high while scanning
//   done   out  one-cycle pulse on pass completion
// -----------------------------------------------------------------------------
module decoder_scan_seq #(
  parameter int DWELL_W = 4,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  output logic               en,
  output logic [ADDR_W-1:0]  addr,
  output logic               busy,
  output logic               done
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  logic               state;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dwell_cnt <= '0;
      dwell_cap <= '0;
      en        <= 1'b0;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // done is a pulse: it is only raised on the edge that completes a pass.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          en   <= 1'b0;
          addr <= '0;
          busy <= 1'b0;
          if (start && !stop) begin
            dwell_cap <= dwell;
            dwell_cnt <= '0;
            state     <= ST_SCAN;
            en        <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ST_SCAN: begin
          if (stop) begin
            state     <= ST_IDLE;
            dwell_cnt <= '0;
            en        <= 1'b0;
            addr      <= '0;
            busy      <= 1'b0;
          end else if (dwell_cnt == dwell_cap) begin
            // The current code has been held for dwell_cap+1 cycles.
            dwell_cnt <= '0;
            if (addr == ADDR_LAST) begin
              done <= 1'b1;
`ifdef SCAN_CONT_EN
              // Wrap with no en gap; stay busy until stop/rst.
              addr <= '0;
`else
              state <= ST_IDLE;
              en    <= 1'b0;
              addr  <= '0;
              busy  <= 1'b0;
`endif
            end else begin
              addr <= addr + 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          en    <= 1'b0;
          addr  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
